// File: rtl/piezo_tone_gen_if.sv
// piezo_tone_gen_if: play request from a sound sequencer and the tone outputs back to it.
// Revision: 1.0
`default_nettype none

interface piezo_tone_gen_if;
  logic        i_play_en;
  logic [31:0] i_pitch;
  logic        o_piezo;
  logic        o_active;
  logic        o_toggle;
  logic [31:0] o_cur_limit;

  modport master (
    output i_play_en, i_pitch,
    input  o_piezo, o_active, o_toggle, o_cur_limit
  );

  modport slave (
    input  i_play_en, i_pitch,
    output o_piezo, o_active, o_toggle, o_cur_limit
  );
endinterface

`default_nettype wire

// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen: square-wave buzzer driver; each half period lasts lim clocks, pitch reloads only at edges.
// Revision: 1.0
`default_nettype none

module piezo_tone_gen #(
  parameter int unsigned MIN_LIMIT = 2500,
  parameter int unsigned MAX_LIMIT = 1000000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  piezo_tone_gen_if.slave  bus
);

  localparam logic [31:0] c_min_lim = 32'(MIN_LIMIT);
  localparam logic [31:0] c_max_lim = 32'(MAX_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lim_q, lim_d;
  logic        piezo_q, piezo_d;
  logic        toggle_q, toggle_d;
  logic        active_q, active_d;

  logic        w_en;
  logic        w_boundary;
  logic [31:0] w_clamped;

  assign w_en       = bus.i_play_en && (bus.i_pitch != 32'd0);
  assign w_boundary = (cnt_q == (lim_q - 32'd1));
  assign w_clamped  = (bus.i_pitch < c_min_lim) ? c_min_lim :
                      (bus.i_pitch > c_max_lim) ? c_max_lim : bus.i_pitch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      lim_q    <= 32'd0;
      piezo_q  <= 1'b0;
      toggle_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
      piezo_q  <= piezo_d;
      toggle_q <= toggle_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    lim_d    = lim_q;
    piezo_d  = piezo_q;
    toggle_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d   = 32'd0;
        lim_d   = 32'd0;
        piezo_d = 1'b0;
        if (w_en) begin
          lim_d   = w_clamped;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (w_boundary) begin
          // The edge is always taken; a stop only decides where we go afterwards.
          piezo_d  = ~piezo_q;
          toggle_d = 1'b1;
          cnt_d    = 32'd0;
          if (w_en) begin
            lim_d = w_clamped;
          end else if (piezo_q) begin
            lim_d   = 32'd0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (!w_en) begin
          if (piezo_q) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d   = 32'd0;
            lim_d   = 32'd0;
            state_d = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (w_boundary) begin
          piezo_d  = 1'b0;
          toggle_d = 1'b1;
          cnt_d    = 32'd0;
          lim_d    = 32'd0;
          state_d  = S_IDLE;
        end else if (w_en) begin
          state_d = S_RUN;
        end
      end

      default: begin
        cnt_d   = 32'd0;
        lim_d   = 32'd0;
        piezo_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  assign bus.o_piezo     = piezo_q;
  assign bus.o_toggle    = toggle_q;
  assign bus.o_active    = active_q;
  assign bus.o_cur_limit = lim_q;

endmodule

`default_nettype wire

// File: tb/tb_piezo_tone_gen.sv
// tb_piezo_tone_gen: directed tone scenarios plus random play/pitch traffic against a half-period model.
// Revision: 1.0
`default_nettype none

module tb_piezo_tone_gen;

  localparam int unsigned MIN_L = 2;
  localparam int unsigned MAX_L = 100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  piezo_tone_gen_if bus ();

  piezo_tone_gen #(
    .MIN_LIMIT (MIN_L),
    .MAX_LIMIT (MAX_L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of the tone: whether it sounds, the pin level, clocks elapsed in the
  // current half, that half's length, and whether a stop is waiting for the fall.
  typedef struct packed {
    logic        on;
    logic        stopping;
    logic        pin;
    logic        tog;
    logic [31:0] el;
    logic [31:0] half;
  } model_t;

  model_t m;

  function automatic logic [31:0] clampf(input logic [31:0] p);
    if (p < MIN_L) return 32'(MIN_L);
    if (p > MAX_L) return 32'(MAX_L);
    return p;
  endfunction

  function automatic model_t step(input model_t s, input logic play, input logic [31:0] p);
    model_t n;
    logic   en;
    n     = s;
    en    = play && (p != 0);
    n.tog = 1'b0;
    if (!s.on) begin
      if (en) begin
        n.on = 1'b1; n.stopping = 1'b0; n.el = 0; n.half = clampf(p);
      end
    end else if (s.el + 1 == s.half) begin
      n.pin = ~s.pin; n.tog = 1'b1; n.el = 0;
      if (s.stopping || (!en && s.pin)) begin
        n.on = 1'b0; n.stopping = 1'b0; n.half = 0;
      end else if (en) begin
        n.half = clampf(p);
      end else begin
        n.stopping = 1'b1;
      end
    end else begin
      n.el = s.el + 1;
      if (s.stopping && en) n.stopping = 1'b0;
      else if (!s.stopping && !en) begin
        if (s.pin) n.stopping = 1'b1;
        else begin
          n.on = 1'b0; n.el = 0; n.half = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, bus.i_play_en, bus.i_pitch);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("piezo",     32'(bus.o_piezo),  32'(m.pin));
      chk("toggle",    32'(bus.o_toggle), 32'(m.tog));
      chk("active",    32'(bus.o_active), 32'(m.on));
      chk("cur_limit", bus.o_cur_limit,   m.half);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the pin reaches v, bounded so a stuck DUT still reaches the summary.
  task automatic wait_pin(input logic v, output int n);
    n = 0;
    while (bus.o_piezo !== v && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_piezo"},  32'(bus.o_piezo),  0);
    chk({tag, "_toggle"}, 32'(bus.o_toggle), 0);
    chk({tag, "_active"}, 32'(bus.o_active), 0);
    chk({tag, "_limit"},  bus.o_cur_limit,   0);
  endtask

  function automatic logic [31:0] pick_pitch();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'($urandom_range(2, 8));
      3:       return 32'($urandom_range(9, 20));
      4:       return 32'($urandom_range(90, 110));
      default: return ($urandom_range(0, 1) == 0) ? 32'd500 : 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    int n;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.i_play_en = 1'b0;
    bus.i_pitch   = 32'd0;
    repeat (3) tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();

    // Basic tone at pitch 4.
    bus.i_play_en = 1'b1;
    bus.i_pitch   = 32'd4;
    tick();
    chk("start_active", 32'(bus.o_active), 1);
    chk("start_limit",  bus.o_cur_limit,   4);
    chk("start_piezo",  32'(bus.o_piezo),  0);
    wait_pin(1'b1, n); chk("first_low_len", n, 4);
    chk("rise_toggle", 32'(bus.o_toggle), 1);
    wait_pin(1'b0, n); chk("high_len", n, 4);

    // Pitch change two clocks into a low half.
    repeat (2) tick();
    bus.i_pitch = 32'd6;
    wait_pin(1'b1, n); chk("pchg_rest_len", n, 2);
    chk("pchg_limit", bus.o_cur_limit, 6);
    wait_pin(1'b0, n); chk("pchg_new_len", n, 6);

    // Stop while low.
    bus.i_play_en = 1'b0;
    tick();
    chk_idle("stop_low");

    // Clamping: 1 -> 2, 500 -> 100.
    bus.i_play_en = 1'b1;
    bus.i_pitch   = 32'd1;
    tick();
    chk("clamp_lo_limit", bus.o_cur_limit, 2);
    wait_pin(1'b1, n); chk("clamp_lo_len", n, 2);
    wait_pin(1'b0, n); chk("clamp_lo_len2", n, 2);
    bus.i_pitch = 32'd500;
    wait_pin(1'b1, n); chk("clamp_hi_prev", n, 2);
    chk("clamp_hi_limit", bus.o_cur_limit, 100);
    wait_pin(1'b0, n); chk("clamp_hi_len", n, 100);

    // Zero pitch with play enabled acts as a stop.
    bus.i_pitch = 32'd0;
    tick();
    chk("zero_active", 32'(bus.o_active), 0);
    chk("zero_limit",  bus.o_cur_limit,   0);

    // Stop while high: pin holds through the half, then drains.
    bus.i_pitch = 32'd10;
    tick();
    wait_pin(1'b1, n); chk("s10_low_len", n, 10);
    repeat (2) tick();
    bus.i_play_en = 1'b0;
    tick();
    chk("drain_piezo",  32'(bus.o_piezo),  1);
    chk("drain_active", 32'(bus.o_active), 1);
    wait_pin(1'b0, n); chk("drain_len", n, 7);
    chk("drain_toggle",  32'(bus.o_toggle), 1);
    chk("drain_active0", 32'(bus.o_active), 0);
    chk("drain_limit0",  bus.o_cur_limit,   0);
    tick();
    chk("drain_tog_once", 32'(bus.o_toggle), 0);

    // Re-raising play during drain continues the tone unbroken.
    bus.i_play_en = 1'b1;
    tick();
    wait_pin(1'b1, n); chk("rr_low_len", n, 10);
    repeat (2) tick();
    bus.i_play_en = 1'b0;
    repeat (2) tick();
    bus.i_play_en = 1'b1;
    wait_pin(1'b0, n); chk("rr_high_rest", n, 6);
    wait_pin(1'b1, n); chk("rr_next_low", n, 10);

    // Asynchronous reset mid-run with the pin high.
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 5000; i++) begin
      int r;
      tick();
      r = int'($urandom_range(0, 99));
      if (r < 3) bus.i_play_en = ~bus.i_play_en;
      else if (r < 9) bus.i_pitch = pick_pitch();
      if (i == 2500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rand_rst");
        tick();
        rst_n = 1'b1;
      end
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piezo_tone_gen.md
# piezo_tone_gen

Square-wave tone generator that drives the piezo buzzer pin from a play-enable and a half-period counter limit, as produced by the sound sequencers such as the intro sweep player. It runs from the 50 MHz system clock and holds each half period for exactly `lim` clocks, so the tone frequency is 50 MHz / (2 × lim). New pitch values are accepted only at half-period boundaries, which keeps sweeps glitch-free. Stopping always leaves the pin low.

## Interface
- `MIN_LIMIT`, default 2500: smallest accepted half-period in clocks (10 kHz ceiling).
- `MAX_LIMIT`, default 1000000: largest accepted half-period in clocks (25 Hz floor).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_play_en`  in  1  tone request level.
- `i_pitch`  in  32  requested half-period in clocks; 0 means silence.
- `o_piezo`  out  1  square wave to the buzzer pin.
- `o_active`  out  1  high in RUN and DRAIN.
- `o_toggle`  out  1  one-clock pulse coincident with every `o_piezo` transition.
- `o_cur_limit`  out  32  latched half-period in use; 0 in IDLE.

## Operation
- Effective enable: `en = i_play_en && (i_pitch != 0)`. Both inputs are sampled every clock.
- Clamp function `clamp(p)`:
  - p < MIN_LIMIT gives MIN_LIMIT.
  - p > MAX_LIMIT gives MAX_LIMIT.
  - Otherwise p.
  - Only evaluated when en=1, so p ≥ 1.
- Internal registers:
  - 32-bit counter `cnt`.
  - Latched limit `lim`, which drives `o_cur_limit`.
  - State register.
- IDLE:
  - `o_piezo`=0, `cnt`=0, `lim`=0.
  - When en=1: `lim` ← clamp(`i_pitch`), `cnt` ← 0, go to RUN.
- RUN:
  - `cnt` increments each clock.
  - When `cnt == lim-1`: toggle `o_piezo`, pulse `o_toggle`, `cnt` ← 0, and `lim` ← clamp(`i_pitch`) sampled on that same clock.
  - If en=0 on a boundary clock, the toggle still happens and no reload occurs (`lim` keeps its value).
  - On any non-boundary clock with en=0:
    - If `o_piezo`=0: go to IDLE.
    - If `o_piezo`=1: go to DRAIN.
- DRAIN:
  - Counting continues.
  - At `cnt == lim-1`: `o_piezo` ← 0, pulse `o_toggle`, go to IDLE.
  - If en returns to 1 before the boundary: go back to RUN without touching `cnt` or `lim`. Normal reload happens at the next boundary.
- Pitch changes in the middle of a half period never shorten or lengthen that half period.
- `o_active` is registered: high exactly when the state is RUN or DRAIN.
- Reset (async, mid-operation included): state IDLE, `o_piezo`=0, `o_toggle`=0, `o_active`=0, `o_cur_limit`=0, `cnt`=0.

## Timing
- Start latency:
  - en first seen high at edge E: RUN, `o_active`=1 and `o_cur_limit` valid after E.
  - `o_piezo` stays 0 until edge E+lim, where it rises.
  - Each level then lasts exactly `lim` clocks; period is 2·lim clocks.
- `o_toggle` is high for the single cycle following each transition edge.
- Stop while low: en low at edge S gives IDLE after S; the pin is already 0.
- Stop while high: the pin falls at the edge that ends the current half period, at most `lim` clocks after stop.
- Simultaneous events:
  - Stop on a boundary clock: the toggle wins.
  - If the pin goes 1→0 on that clock, the state goes to IDLE.
  - If the pin goes 0→1 on that clock, the state goes to DRAIN.
- Clamped reload takes effect at the same edge as the toggle.

## Test plan
- Reset check: assert `rst_n`=0 mid-RUN with `o_piezo`=1 → `o_piezo`, `o_active`, `o_toggle`, `o_cur_limit` all 0 immediately, with no clock edge required.
- Basic tone (MIN_LIMIT=2, MAX_LIMIT=100): en=1, pitch=4 → `o_piezo` low 4 clocks, then toggles every 4 clocks; `o_toggle` pulses at each edge; `o_cur_limit`=4.
- Pitch change: pitch 4→6 issued 2 clocks into a half period → that half period stays 4 clocks, following ones last 6, and `o_cur_limit`=6 from the toggle edge.
- Clamping: pitch=1 → half period 2; pitch=500 → half period 100; pitch=0 with play_en=1 → behaves as a stop.
- Stop while high, pitch=10, en dropped 3 clocks into a high half → `o_piezo` stays 1 for 7 more clocks, falls with one `o_toggle` pulse, then IDLE and `o_active`=0. Re-raising en during DRAIN instead continues the tone with unbroken 10-clock halves.
- Stop while low → IDLE on the next clock, `o_piezo` remains 0, no `o_toggle` pulse; a restart gives the first rise exactly `lim` clocks later.
